// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, winner encoding and address-fault helper for mem_arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  typedef enum logic {WIN_IF = 1'b0, WIN_D = 1'b1} win_t;
  localparam int MEM_ADDR_BITS_DEF = 14;
  function automatic logic addr_fault(input logic [31:0] a, input int bits);
    return (a[1:0] != 2'b00) || ((a >> bits) != 32'd0);
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (ifetch/data) arbiter onto a single word memory.
// Data wins by default; ifetch wins after STARVE_LIMIT consecutive losses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT  = 4,
  parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic [31:0] mem_data_out
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  state_t      r_state;
  win_t        r_win;
  logic [CW-1:0] r_starve;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_idle, w_starved, w_if_win, w_gnt, w_fault, w_resp;
  logic [31:0] w_addr;
  // gating with resetn keeps grants and memory strobes quiet during reset
  assign w_idle    = resetn && (r_state == IDLE);
  assign w_starved = (r_starve == CW'(STARVE_LIMIT));
  assign w_if_win  = if_req && (!d_req || w_starved);
  assign if_gnt    = w_idle && w_if_win;
  assign d_gnt     = w_idle && d_req && !w_if_win;
  assign w_gnt     = if_gnt || d_gnt;
  assign w_addr    = if_gnt ? if_addr : d_gnt ? d_addr : 32'd0;
  assign w_fault   = addr_fault(w_addr, MEM_ADDR_BITS);
  assign mem_address = w_addr;
  assign mem_data_in = w_gnt ? d_wdata : 32'd0;
  assign mem_we      = d_gnt && d_we && !w_fault;
  assign w_resp    = (r_state == RESP);
  assign if_rvalid = w_resp && (r_win == WIN_IF);
  assign d_rvalid  = w_resp && (r_win == WIN_D);
  assign if_rdata  = if_rvalid ? r_rdata : 32'd0;
  assign d_rdata   = d_rvalid ? r_rdata : 32'd0;
  assign if_err    = if_rvalid && r_err;
  assign d_err     = d_rvalid && r_err;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_win    <= WIN_IF;
      r_starve <= '0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_gnt ? RESP : IDLE;
      if (w_gnt) begin
        r_win   <= d_gnt ? WIN_D : WIN_IF;
        r_err   <= w_fault;
        r_rdata <= (w_fault || (d_gnt && d_we)) ? 32'd0 : mem_data_out;
      end
      if (r_state == IDLE)
        r_starve <= (if_gnt || !if_req) ? '0 : (d_gnt && !w_starved) ? r_starve + CW'(1) : r_starve;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning consecutive lost arbitrations after which ifetch wins.
REQ-002 Parameter MEM_ADDR_BITS, default 14, meaning byte-address width of the 16 KB word memory.
REQ-003 Port list (name, direction, width, meaning), which SHALL be exactly:
- clk  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- if_req  in  1  ifetch request, held until granted
- if_addr  in  32  ifetch byte address
- if_gnt  out  1  ifetch request accepted this cycle
- if_rvalid  out  1  ifetch response valid, one cycle
- if_rdata  out  32  ifetch read data
- if_err  out  1  ifetch access fault, qualifies if_rvalid
- d_req  in  1  data request, held until granted
- d_we  in  1  data request is a word store
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid, one cycle
- d_rdata  out  32  load data, 0 for stores
- d_err  out  1  data access fault, qualifies d_rvalid
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory write data
- mem_we  out  1  to memory write enable
- mem_data_out  in  32  from memory, combinational read of mem_address

Function
REQ-004 The FSM SHALL have two states: IDLE (may grant) and RESP (response cycle, no grant).
REQ-005 In IDLE, with any request pending, exactly one gnt SHALL assert combinationally; the state moves to RESP on the next edge.
REQ-006 Arbitration: d_req wins over if_req, unless starve_cnt == STARVE_LIMIT, in which case if_req wins.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_LIMIT) when if_req loses to d_req, and clear when ifetch is granted or if_req is low in IDLE.
REQ-008 In the grant cycle, mem_address SHALL equal the winner's address and mem_data_in SHALL equal d_wdata; otherwise mem_address = 0 and mem_data_in = 0.
REQ-009 A fault is addr[1:0] != 0 or addr[31:MEM_ADDR_BITS] != 0.
REQ-010 mem_we SHALL equal d_gnt & d_we & ~fault; ifetch SHALL never write.
REQ-011 At the grant edge, the arbiter SHALL register mem_data_out (load/fetch, no fault) or 0 (store or fault), plus the fault bit and the winner id.
REQ-012 In RESP, exactly the winner's rvalid SHALL assert for one cycle with registered rdata/err; the state then returns to IDLE.
REQ-013 Latency: grant in cycle N, rvalid in N+1, next grant earliest in N+2; peak throughput one access per 2 cycles.
REQ-014 Requests arriving during RESP SHALL wait; gnt SHALL never assert in RESP.
REQ-015 Simultaneous if_req and d_req at the limit: ifetch SHALL be granted, and d_req stays pending, not counted.
REQ-016 The rdata/err outputs of the non-responding port SHALL be 0.

Reset
REQ-017 resetn low SHALL asynchronously force state IDLE, starve_cnt 0, response registers 0, and all gnt/rvalid/err/rdata/mem_* outputs 0.
REQ-018 Reset asserted in RESP SHALL drop the pending response, with no rvalid after release.
REQ-019 No gnt or mem_we SHALL assert while resetn is low.

Structure
REQ-020 The shared package mem_arb_pkg SHALL hold the state enum (IDLE, RESP), the winner-id encoding (WIN_IF, WIN_D) and the MEM_ADDR_BITS default.
REQ-021 The design SHALL be a single module with no sub-module; the starvation counter is inline.

Verification
REQ-022 if_req only, if_addr=0x00000004, mem word1=0x00100093 -> if_gnt in cycle N, if_rvalid in N+1 with if_rdata=0x00100093, if_err=0.
REQ-023 d_req store d_addr=0x10, d_wdata=0xDEADBEEF, then a load of 0x10 -> mem_we for exactly one cycle; the load returns 0xDEADBEEF.
REQ-024 if_req and d_req held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,IF, repeating; each grant is 2 cycles apart.
REQ-025 d_addr=0x00000006 load, then d_addr=0x00004000 store -> d_err=1 on both responses, d_rdata=0, mem_we never asserted.
REQ-026 resetn pulsed low during RESP of a fetch -> no if_rvalid, all outputs 0, first grant on the first edge after release.
